// File: rtl/exu_pkg.sv
// Shared definitions for the execution-unit sequencer: unit and opcode
// encodings, FSM state encoding, multi-cycle latencies and the pending-op
// record latched at issue.
package exu_pkg;

  // Unit select encoding carried on iExuOp / oUnitSel.
  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MDU = 2'd1;
  localparam logic [1:0] UNIT_FPU = 2'd2;
  localparam logic [1:0] UNIT_ILL = 2'd3;

  // MDU opcodes.
  localparam logic MDU_MUL = 1'b0;
  localparam logic MDU_DIV = 1'b1;

  // FPU opcodes; 4..7 are the short "misc" group.
  localparam logic [2:0] FPU_ADD = 3'd0;
  localparam logic [2:0] FPU_SUB = 3'd1;
  localparam logic [2:0] FPU_MUL = 3'd2;
  localparam logic [2:0] FPU_DIV = 3'd3;

  // Total latency in cycles from issue (T) to the result cycle (T+LAT).
  localparam logic [5:0] LAT_ALU  = 6'd1;
  localparam logic [5:0] LAT_MUL  = 6'd3;
  localparam logic [5:0] LAT_DIV  = 6'd32;
  localparam logic [5:0] LAT_FADD = 6'd4;
  localparam logic [5:0] LAT_FMUL = 6'd5;
  localparam logic [5:0] LAT_FDIV = 6'd16;
  localparam logic [5:0] LAT_FMSC = 6'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } exu_state_e;

  // Destination info captured at issue and replayed with the result.
  typedef struct packed {
    logic [4:0] addr;
    logic       en;
    logic [1:0] unit;
  } exu_pend_t;

  // True for units that occupy the sequencer for more than one cycle.
  function automatic logic isMcUnit(input logic [1:0] unit);
    return (unit == UNIT_MDU) || (unit == UNIT_FPU);
  endfunction

endpackage

// File: rtl/exu_lat_lut.sv
// Purpose: map a unit/opcode pair to its total execution latency.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
//
// Ports:
//   iUnit   unit select (ALU/MDU/FPU/illegal)
//   iMduOp  MDU opcode (multiply/divide)
//   iFpuOp  FPU opcode
//   oLat    total latency in cycles (ALU and illegal report 1)
module exu_lat_lut
  import exu_pkg::*;
(
  input  logic [1:0] iUnit,
  input  logic       iMduOp,
  input  logic [2:0] iFpuOp,
  output logic [5:0] oLat
);

  always_comb begin
    oLat = LAT_ALU;
    case (iUnit)
      UNIT_MDU: oLat = (iMduOp == MDU_DIV) ? LAT_DIV : LAT_MUL;
      UNIT_FPU: begin
        case (iFpuOp)
          FPU_ADD, FPU_SUB: oLat = LAT_FADD;
          FPU_MUL:          oLat = LAT_FMUL;
          FPU_DIV:          oLat = LAT_FDIV;
          default:          oLat = LAT_FMSC;
        endcase
      end
      default: oLat = LAT_ALU;
    endcase
  end

endmodule

// File: rtl/exu_sequencer.sv
// Purpose: sequence multi-cycle MDU/FPU ops, stalling the pipeline until the result is taken.
// Latency: result presented LAT cycles after issue (MUL 3, DIV 32, FADD/FSUB 4, FMUL 5, FDIV 16, misc 2).
// Backpressure: iMemStall holds the finished result (and oStall) until downstream accepts it.
//
// Ports:
//   iClk, iRst_n            clock; synchronous active-low reset
//   iIssueValid, iExuOp     instruction valid and unit select
//   iMduOp, iFpuOp          opcode within the selected unit
//   iWriteAddr, iWriteEn    destination of the issued op
//   iFlush                  mispredict flush, kills any pending op
//   iMemStall               downstream cannot accept a result
//   oStall                  freeze fetch/decode/execute registers
//   oBusy                   sequencer holds a pending op
//   oResultValid            multi-cycle result presented this cycle
//   oWriteAddr/oWriteEn     latched destination (oWriteEn qualified by oResultValid)
//   oUnitSel                latched unit, selects the result mux
//   oIllegal                registered one-cycle pulse for an illegal unit select
//   oStallCycles/oMcOpCount performance counters, only with EXU_PERF_CNT_EN defined
module exu_sequencer
  import exu_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iIssueValid,
  input  logic [1:0]  iExuOp,
  input  logic        iMduOp,
  input  logic [2:0]  iFpuOp,
  input  logic [4:0]  iWriteAddr,
  input  logic        iWriteEn,
  input  logic        iFlush,
  input  logic        iMemStall,
  output logic        oStall,
  output logic        oBusy,
  output logic        oResultValid,
  output logic [4:0]  oWriteAddr,
  output logic        oWriteEn,
  output logic [1:0]  oUnitSel,
  output logic        oIllegal
`ifdef EXU_PERF_CNT_EN
  ,
  output logic [31:0] oStallCycles,
  output logic [31:0] oMcOpCount
`endif
);

  exu_state_e stateQ, stateD;
  logic [5:0] cntQ, cntD;
  exu_pend_t  pendQ, pendD;
  logic       illegalQ;
  logic [5:0] lat;
  logic       issueMc;
  logic       issueIll;
  logic       stall;
  logic       resultValid;

  exu_lat_lut uLatLut (
    .iUnit  (iExuOp),
    .iMduOp (iMduOp),
    .iFpuOp (iFpuOp),
    .oLat   (lat)
  );

  // Issues are only looked at in IDLE; a flush in the same cycle kills them.
  assign issueMc  = (stateQ == ST_IDLE) && iIssueValid && !iFlush && isMcUnit(iExuOp);
  assign issueIll = (stateQ == ST_IDLE) && iIssueValid && !iFlush && (iExuOp == UNIT_ILL);

  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    pendD       = pendQ;
    stall       = 1'b0;
    resultValid = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (issueMc) begin
          stateD = ST_EXEC;
          // EXEC spans LAT-1 cycles and leaves on cnt==0, so start at LAT-2.
          cntD   = lat - 6'd2;
          pendD  = '{addr: iWriteAddr, en: iWriteEn, unit: iExuOp};
          stall  = 1'b1;
        end
      end
      ST_EXEC: begin
        stall = 1'b1;
        if (iFlush) begin
          stateD = ST_IDLE;
        end else if (cntQ == 6'd0) begin
          stateD = ST_DONE;
        end else begin
          cntD = cntQ - 6'd1;
        end
      end
      ST_DONE: begin
        // Holding the result under memory backpressure must also hold the
        // instruction behind it, so stall follows iMemStall here.
        stall = iMemStall;
        if (iFlush) begin
          stateD = ST_IDLE;
        end else begin
          resultValid = 1'b1;
          if (!iMemStall) begin
            stateD = ST_IDLE;
          end
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      stateQ   <= ST_IDLE;
      cntQ     <= 6'd0;
      pendQ    <= '0;
      illegalQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      pendQ    <= pendD;
      illegalQ <= issueIll;
    end
  end

  assign oStall       = stall;
  assign oBusy        = (stateQ != ST_IDLE);
  assign oResultValid = resultValid;
  assign oWriteAddr   = pendQ.addr;
  assign oWriteEn     = resultValid && pendQ.en;
  assign oUnitSel     = pendQ.unit;
  assign oIllegal     = illegalQ;

`ifdef EXU_PERF_CNT_EN
  logic [31:0] stallCntQ;
  logic [31:0] mcOpCntQ;

  // Free-running wrapping counters; cleared only by reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      stallCntQ <= 32'd0;
      mcOpCntQ  <= 32'd0;
    end else begin
      if (stall) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
      if (issueMc) begin
        mcOpCntQ <= mcOpCntQ + 32'd1;
      end
    end
  end

  assign oStallCycles = stallCntQ;
  assign oMcOpCount   = mcOpCntQ;
`endif

endmodule
